// File: rtl/ir_weight_bank_if.sv
// Bus bundle for the IR weight bank: coefficient load stream, slot select,
// and the convolver tap-read port.
interface ir_weight_bank_if #(
  parameter int TAPS  = 128,
  parameter int WIDTH = 16,
  parameter int SLOTS = 4
);
  localparam int SW = $clog2(SLOTS);
  localparam int TW = $clog2(TAPS);

  logic                    ld_start;
  logic [SW-1:0]           ld_slot;
  logic                    ld_valid;
  logic                    ld_ready;
  logic signed [WIDTH-1:0] ld_data;
  logic                    ld_done;
  logic                    ld_err;
  logic                    sel_req;
  logic [SW-1:0]           sel_slot;
  logic                    frame_start;
  logic [SW-1:0]           active_slot;
  logic                    rd_en;
  logic [TW-1:0]           rd_addr;
  logic signed [WIDTH-1:0] rd_data;
  logic [SLOTS-1:0]        slot_valid;

  modport master (
    output ld_start, ld_slot, ld_valid, ld_data, sel_req, sel_slot,
           frame_start, rd_en, rd_addr,
    input  ld_ready, ld_done, ld_err, active_slot, rd_data, slot_valid
  );

  modport slave (
    input  ld_start, ld_slot, ld_valid, ld_data, sel_req, sel_slot,
           frame_start, rd_en, rd_addr,
    output ld_ready, ld_done, ld_err, active_slot, rd_data, slot_valid
  );
endinterface

// File: rtl/ir_weight_bank.sv
// Multi-slot impulse-response coefficient bank. One slot is active for the
// convolver while any other slot may be reloaded; slot switches happen only
// on frame boundaries and only to fully loaded slots.
module ir_weight_bank #(
  parameter int TAPS  = 128,
  parameter int WIDTH = 16,
  parameter int SLOTS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ir_weight_bank_if.slave bus
);
  localparam int SW = $clog2(SLOTS);
  localparam int TW = $clog2(TAPS);
  localparam int AW = SW + TW;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [SLOTS-1:0]        slot_valid_q, slot_valid_d;
  logic                    ld_err_q, ld_err_d;
  logic [SW-1:0]           active_q, active_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [SW-1:0]           pend_slot_q, pend_slot_d;
  logic                    rd_gate_q, rd_gate_d;
  logic                    start_conflict;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [AW-1:0]           rd_addr_full;

  // Coefficient storage, addressed {slot, tap}; contents are never reset.
  logic signed [WIDTH-1:0] mem [0:SLOTS*TAPS-1];
  logic signed [WIDTH-1:0] ram_rd_q;

  assign wr_addr      = {slot_q, cnt_q};
  assign rd_addr_full = {active_q, bus.rd_addr};

  // Load FSM: accept a start to a free slot, stream TAPS words, then mark valid.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    cnt_d          = cnt_q;
    slot_valid_d   = slot_valid_q;
    ld_err_d       = 1'b0;
    wr_en          = 1'b0;
    // A slot in use (or about to be) must never be overwritten.
    start_conflict = (bus.ld_slot == active_q) ||
                     (pend_vld_q && (bus.ld_slot == pend_slot_q));
    case (state_q)
      IDLE: begin
        if (bus.ld_start) begin
          if (start_conflict) begin
            ld_err_d = 1'b1;
          end else begin
            slot_d                      = bus.ld_slot;
            cnt_d                       = '0;
            slot_valid_d[bus.ld_slot]   = 1'b0;
            state_d                     = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + TW'(1);
          if (cnt_q == TW'(TAPS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        slot_valid_d[slot_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot select: latest request wins; applied on a frame boundary if the slot is loaded.
  always_comb begin
    active_d    = active_q;
    pend_vld_d  = pend_vld_q;
    pend_slot_d = pend_slot_q;
    if (bus.frame_start) begin
      if (pend_vld_q && slot_valid_q[pend_slot_q]) begin
        active_d = pend_slot_q;
      end
      pend_vld_d = 1'b0;
    end
    // A request arriving with frame_start waits for the following frame.
    if (bus.sel_req) begin
      pend_vld_d  = 1'b1;
      pend_slot_d = bus.sel_slot;
    end
  end

  // Read gate: remembers whether the last read hit a loaded slot.
  always_comb begin
    rd_gate_d = rd_gate_q;
    if (bus.rd_en) begin
      rd_gate_d = slot_valid_q[active_q];
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      cnt_q        <= '0;
      slot_valid_q <= '0;
      ld_err_q     <= 1'b0;
      active_q     <= '0;
      pend_vld_q   <= 1'b0;
      pend_slot_q  <= '0;
      rd_gate_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
      ld_err_q     <= ld_err_d;
      active_q     <= active_d;
      pend_vld_q   <= pend_vld_d;
      pend_slot_q  <= pend_slot_d;
      rd_gate_q    <= rd_gate_d;
    end
  end

  // Simple dual-port RAM: load writes, convolver reads with one-cycle latency.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.ld_data;
    end
    if (bus.rd_en) begin
      ram_rd_q <= mem[rd_addr_full];
    end
  end

  assign bus.ld_ready    = (state_q == LOAD);
  assign bus.ld_done     = (state_q == DONE);
  assign bus.ld_err      = ld_err_q;
  assign bus.active_slot = active_q;
  assign bus.slot_valid  = slot_valid_q;
  assign bus.rd_data     = rd_gate_q ? ram_rd_q : '0;
endmodule

// File: tb/tb_ir_weight_bank.sv
// Randomized scoreboard bench for ir_weight_bank.
`timescale 1ns/1ps
module tb_ir_weight_bank;
  localparam int TAPS  = 128;
  localparam int WIDTH = 16;
  localparam int SLOTS = 4;
  localparam int SW    = $clog2(SLOTS);
  localparam int TW    = $clog2(TAPS);

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ir_weight_bank_if #(.TAPS(TAPS), .WIDTH(WIDTH), .SLOTS(SLOTS)) bus ();

  ir_weight_bank #(.TAPS(TAPS), .WIDTH(WIDTH), .SLOTS(SLOTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { longint cyc; int rc; } done_t;
  done_t            done_q[$];
  longint           err_q[$];
  logic [WIDTH-1:0] rd_q[$];

  // Reference model: stored words, loaded flags, active and pending select.
  logic [WIDTH-1:0] m_mem [SLOTS][TAPS];
  logic [SLOTS-1:0] m_valid  = '0;
  logic [SW-1:0]    m_active = '0;
  bit               m_pv     = 1'b0;
  logic [SW-1:0]    m_pend   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_start    = 1'b0;
    m_valid         = '0;
    m_active        = '0;
    m_pv            = 1'b0;
    m_pend          = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // One cycle of select / frame / read traffic, applied to the model by the rules.
  task automatic cycle_op(input bit sel, input int sslot, input bit frame,
                          input bit rd, input int addr);
    if (rd) rd_q.push_back(m_valid[m_active] ? m_mem[m_active][addr] : '0);
    bus.sel_req     = sel;
    bus.sel_slot    = SW'(sslot);
    bus.frame_start = frame;
    bus.rd_en       = rd;
    bus.rd_addr     = TW'(addr);
    step();
    bus.sel_req     = 1'b0;
    bus.frame_start = 1'b0;
    bus.rd_en       = 1'b0;
    if (frame) begin
      if (m_pv && m_valid[m_pend]) m_active = m_pend;
      m_pv = 1'b0;
    end
    if (sel) begin
      m_pv   = 1'b1;
      m_pend = SW'(sslot);
    end
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random. dmode: 0 ramp, 1 random.
  task automatic do_load(input int slot, input int vmode, input int dmode, input int abort_at);
    int               k, n;
    bit               v;
    longint           w;
    logic [WIDTH-1:0] data;
    bus.ld_start = 1'b1;
    bus.ld_slot  = SW'(slot);
    if (SW'(slot) == m_active || (m_pv && SW'(slot) == m_pend)) begin
      err_q.push_back(cyc + 1);
      step();
      bus.ld_start = 1'b0;
      check("err_fsm_idle_ready", bus.ld_ready, 0);
      step();
      return;
    end
    step();
    bus.ld_start  = 1'b0;
    m_valid[slot] = 1'b0;
    k = 0;
    n = 0;
    w = 0;
    while (k < TAPS) begin
      if (abort_at >= 0 && k == abort_at) begin
        do_reset();
        check("abort_ld_ready", bus.ld_ready, 0);
        check("abort_rd_data", $unsigned(bus.rd_data), 0);
        return;
      end
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      data = (dmode == 0 && v) ? WIDTH'(k) : WIDTH'($urandom);
      bus.ld_valid = v;
      bus.ld_data  = data;
      if (n == 7) begin
        bus.ld_start = 1'b1;
        bus.ld_slot  = m_active;
      end
      w = cyc;
      step();
      bus.ld_start = 1'b0;
      n++;
      if (v) begin
        m_mem[slot][k] = data;
        k++;
      end
    end
    bus.ld_valid = 1'b0;
    done_q.push_back('{cyc: w + 1, rc: n});
    step();
    m_valid[slot] = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin
    bit               prev_rd;
    int               rc;
    logic [WIDTH-1:0] last_exp;
    logic [WIDTH-1:0] e;
    done_t            d;
    longint           ec;
    prev_rd  = 1'b0;
    rc       = 0;
    last_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd  = 1'b0;
        rc       = 0;
        last_exp = '0;
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_ld_done", bus.ld_done, 0);
        check("rst_ld_err", bus.ld_err, 0);
        check("rst_rd_data", $unsigned(bus.rd_data), 0);
      end else begin
        if (prev_rd) begin
          if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            e = rd_q.pop_front();
            last_exp = e;
            check("rd_data", $unsigned(bus.rd_data), e);
          end
        end else begin
          check("rd_data_hold", $unsigned(bus.rd_data), last_exp);
        end
        if (bus.ld_ready) rc++;
        if (bus.ld_done) begin
          if (done_q.size() == 0) check("ld_done_unexpected", 1, 0);
          else begin
            d = done_q.pop_front();
            check("ld_done_cycle", cyc, d.cyc);
            check("ld_ready_cycles", rc, d.rc);
          end
          rc = 0;
        end
        if (bus.ld_err) begin
          if (err_q.size() == 0) check("ld_err_unexpected", 1, 0);
          else begin
            ec = err_q.pop_front();
            check("ld_err_cycle", cyc, ec);
          end
        end
        prev_rd = bus.rd_en;
      end
      check("active_slot", bus.active_slot, m_active);
      check("slot_valid", bus.slot_valid, m_valid);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ld_start    = 1'b0;
    bus.ld_slot     = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.sel_req     = 1'b0;
    bus.sel_slot    = '0;
    bus.frame_start = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    #1;
    do_reset();

    cycle_op(0, 0, 0, 1, 3);
    do_load(0, 0, 0, -1);
    do_load(1, 0, 0, -1);
    do_load(1, 1, 0, -1);

    cycle_op(1, 1, 0, 0, 0);
    cycle_op(0, 0, 1, 0, 0);
    cycle_op(0, 0, 0, 1, 5);
    for (int i = 0; i < 8; i++) cycle_op(0, 0, 0, 1, $urandom_range(0, TAPS - 1));
    cycle_op(0, 0, 0, 1, TAPS - 1);

    do_load(1, 2, 1, -1);
    cycle_op(1, 2, 0, 0, 0);
    cycle_op(0, 0, 1, 0, 0);

    do_load(3, 2, 1, -1);
    cycle_op(1, 3, 1, 1, $urandom_range(0, TAPS - 1));
    do_load(3, 0, 1, -1);
    cycle_op(0, 0, 1, 1, $urandom_range(0, TAPS - 1));
    for (int i = 0; i < 10; i++) cycle_op(0, 0, 0, 1, $urandom_range(0, TAPS - 1));
    repeat (3) step();

    cycle_op(1, 2, 0, 0, 0);
    cycle_op(1, 1, 0, 0, 0);
    cycle_op(0, 0, 1, 0, 0);
    cycle_op(1, 1, 0, 0, 0);
    cycle_op(1, 0, 0, 0, 0);
    cycle_op(0, 0, 1, 1, 0);
    cycle_op(0, 0, 0, 1, 9);

    do_load(2, 0, 0, 60);
    cycle_op(0, 0, 0, 1, 60);
    do_load(2, 2, 1, -1);
    cycle_op(1, 2, 0, 0, 0);
    cycle_op(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle_op(0, 0, 0, 1, $urandom_range(0, TAPS - 1));

    repeat (4) step();
    check("rd_queue_drained", rd_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
